// File: rtl/mult_frame_acc_if.sv
// Handshake bundle between the multiplier product stream, mult_frame_acc and its frame-sum consumer.
interface mult_frame_acc_if #(
  parameter int N   = 4,
  parameter int M   = 4,
  parameter int LEN = 8
);
  localparam int ACC_W = N + M + $clog2(LEN);

  logic             in_valid;
  logic [N+M-1:0]   in_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_sum
  );
endinterface

// File: rtl/mult_frame_acc.sv
// Sums every LEN products into a frame sum and queues sums in a 2-entry FIFO with valid/ready.
// Define MULT_FRAME_ACC_DROP_CNT_EN to add the saturating 8-bit drop_cnt_o counter of dropped frames.
module mult_frame_acc #(
  parameter int N   = 4,
  parameter int M   = 4,
  parameter int LEN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  mult_frame_acc_if.slave     bus,
  output logic                busy_o,
  output logic                overflow_o
`ifdef MULT_FRAME_ACC_DROP_CNT_EN
  ,
  output logic [7:0]          drop_cnt_o
`endif
);
  localparam int ACC_W = N + M + $clog2(LEN);
  localparam int CNT_W = $clog2(LEN);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] mem_q [2];
  logic             rd_ptr_q, wr_ptr_q;
  logic [1:0]       level_q, level_d;
  logic             overflow_q;

  logic             accept, last, complete, pop, push, drop;
  logic [ACC_W-1:0] sum;

  assign accept   = bus.in_valid & ~clear_i;
  assign last     = (cnt_q == CNT_W'(LEN - 1));
  assign complete = accept & last;
  assign pop      = (level_q != 2'd0) & bus.out_ready;
  // A pop frees the slot before the push lands, so a full queue still accepts.
  assign push     = complete & ((level_q != 2'd2) | pop);
  assign drop     = complete & ~push;
  assign sum      = acc_q + ACC_W'(bus.in_data);

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      level_q    <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      if (push) begin
        mem_q[wr_ptr_q] <= sum;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef MULT_FRAME_ACC_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

  assign bus.out_valid = (level_q != 2'd0);
  assign bus.out_sum   = mem_q[rd_ptr_q];
  assign busy_o        = (cnt_q != '0);
  assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_mult_frame_acc.sv
// Self-checking bench for mult_frame_acc: directed scenarios plus random traffic against a queue-based model.
module tb_mult_frame_acc;
  localparam int N     = 4;
  localparam int M     = 4;
  localparam int LEN   = 8;
  localparam int ACC_W = N + M + $clog2(LEN);

  logic clk;
  logic rst;
  logic clear;
  logic busy;
  logic overflow;
`ifdef MULT_FRAME_ACC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  mult_frame_acc_if #(.N(N), .M(M), .LEN(LEN)) ifc ();

  mult_frame_acc #(.N(N), .M(M), .LEN(LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (clear),
    .bus        (ifc),
    .busy_o     (busy),
    .overflow_o (overflow)
`ifdef MULT_FRAME_ACC_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: queued frame sums, running partial sum and sample count.
  int q[$];
  int part  = 0;
  int nsamp = 0;
  int m_ovf = 0;
  int drops = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit v, input int d, input bit rdy, input bit clr, input bit r);
    if (r) begin
      q.delete();
      part  = 0;
      nsamp = 0;
      m_ovf = 0;
      drops = 0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (clr) begin
        part  = 0;
        nsamp = 0;
      end else if (v) begin
        part  += d;
        nsamp += 1;
        if (nsamp == LEN) begin
          if (q.size() < 2) q.push_back(part);
          else begin
            m_ovf = 1;
            if (drops < 255) drops++;
          end
          part  = 0;
          nsamp = 0;
        end
      end
    end
  endtask

  task automatic cyc(input bit v, input int d, input bit rdy, input bit clr, input bit r);
    logic [N+M-1:0] dv;
    dv            = (N+M)'(d);
    ifc.in_valid  = v;
    ifc.in_data   = dv;
    ifc.out_ready = rdy;
    clear         = clr;
    rst           = r;
    @(posedge clk);
    model_step(v, d, rdy, clr, r);
    #1;
    chk("out_valid", int'(ifc.out_valid), int'(q.size() != 0));
    if (q.size() != 0) chk("out_sum", int'(ifc.out_sum), q[0]);
    chk("busy", int'(busy), int'(nsamp != 0));
    chk("overflow", int'(overflow), m_ovf);
`ifdef MULT_FRAME_ACC_DROP_CNT_EN
    chk("drop_cnt", int'(drop_cnt), drops);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int pops;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.out_ready = 1'b0;
    clear         = 1'b0;
    rst           = 1'b1;

    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", int'(ifc.out_valid), 0);
    chk("rst_out_sum", int'(ifc.out_sum), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);

    // Single frame 1..8
    for (int i = 1; i <= LEN; i++) cyc(1'b1, i, 1'b1, 1'b0, 1'b0);
    chk("single_sum", int'(ifc.out_sum), 36);
    chk("single_valid", int'(ifc.out_valid), 1);
    cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("single_pulse", int'(ifc.out_valid), 0);

    // Maximum products
    for (int i = 0; i < LEN; i++) cyc(1'b1, 225, 1'b1, 1'b0, 1'b0);
    chk("max_sum", int'(ifc.out_sum), 1800);
    drain();

    // Three all-one frames with random gaps
    begin
      int fed;
      fed = 0;
      while (fed < 3 * LEN) begin
        bit v;
        v = ($urandom_range(0, 1) == 1);
        cyc(v, 1, 1'b1, 1'b0, 1'b0);
        if (v) fed++;
      end
    end
    drain();

    // Backpressure: three frames, third dropped
    for (int i = 0; i < 3 * LEN; i++) cyc(1'b1, $urandom_range(0, 225), 1'b0, 1'b0, 1'b0);
    chk("bp_overflow", int'(overflow), 1);
`ifdef MULT_FRAME_ACC_DROP_CNT_EN
    chk("bp_drop_cnt", int'(drop_cnt), 1);
`endif
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.out_valid) pops++;
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    chk("bp_pops", pops, 2);

    // Full queue with a pop on the completing edge
    cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2 * LEN + LEN - 1; i++) cyc(1'b1, $urandom_range(0, 225), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b1, 1'b0, 1'b0);
    chk("full_pop_overflow", int'(overflow), 0);
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifc.out_valid) pops++;
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    end
    chk("full_pop_count", pops, 2);

    // clear coincident with 6th sample, then a clean frame
    for (int i = 1; i <= 5; i++) cyc(1'b1, i, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 6, 1'b1, 1'b1, 1'b0);
    chk("clear_busy", int'(busy), 0);
    for (int i = 1; i <= LEN; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    chk("clear_next_sum", int'(ifc.out_sum), 36);
    chk("clear_next_valid", int'(ifc.out_valid), 1);
    for (int i = 1; i <= 3; i++) cyc(1'b1, i, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 9, 1'b1, 1'b1, 1'b1);
    chk("rst2_out_valid", int'(ifc.out_valid), 0);
    chk("rst2_out_sum", int'(ifc.out_sum), 0);
    chk("rst2_busy", int'(busy), 0);
    chk("rst2_overflow", int'(overflow), 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 225),
          $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0,
          $urandom_range(0, 499) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mult_frame_acc.md
# mult_frame_acc

Downstream consumer of the pipelined multiplier's `result_ready`/`result` stream. It sums every `LEN` consecutive products into one frame sum (dot-product style) and buffers completed sums in a 2-entry output queue with a valid/ready handshake. The multiplier has no backpressure, so this block absorbs downstream stalls and flags any frame it cannot store.

## Interface
Parameters:
- `N`, default 4: multiplicand width; matches the multiplier's `N`.
- `M`, default 4: multiplier width; matches the multiplier's `M`.
- `LEN`, default 8: products per frame. Must be ≥ 2.
- `ACC_W`, derived: `N+M+$clog2(LEN)`, the accumulator and output width. Not overridable.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock. All logic updates on the rising edge.
- `rst`  in  1: synchronous active-high reset.
- `clear`  in  1: abort the current partial frame.
- `in_valid`  in  1: product strobe; driven by the multiplier's `result_ready`.
- `in_data`  in  N+M: unsigned product; driven by the multiplier's `result`.
- `out_valid`  out  1: head of the output queue is valid.
- `out_ready`  in  1: consumer accepts the head entry.
- `out_sum`  out  ACC_W: frame sum at the head of the queue.
- `busy`  out  1: a partial frame is in progress (`cnt != 0`).
- `overflow`  out  1: sticky flag; set when a completed frame was dropped.

## Operation
- Registers:
  - `acc[ACC_W-1:0]`
  - `cnt` (0..LEN-1)
  - 2-entry FIFO: `mem[2]`, `rd_ptr`, `wr_ptr`, `level` (0..2)
  - `overflow`
- State is implied by `cnt`:
  - IDLE when `cnt == 0`.
  - ACC when `cnt` is 1..LEN-1.
- Accepted sample (`in_valid=1`, `clear=0`):
  - If `cnt < LEN-1`: `acc <= acc + in_data` (zero-extended), `cnt <= cnt+1`.
  - If `cnt == LEN-1` (frame completes): push `acc + in_data` to the FIFO, `acc <= 0`, `cnt <= 0`. Back-to-back frames run with no bubble.
- Arithmetic is unsigned. `ACC_W` guard bits make wrap-around of `acc` impossible.
- Pop: when `out_valid && out_ready`, `rd_ptr` advances and `level` decrements.
- Push into a full FIFO (`level == 2`):
  - With a simultaneous pop: the pop takes effect first, the push is accepted, and `level` stays 2.
  - Without a pop: the sum is discarded, `overflow <= 1`, and the accumulator still clears.
- `overflow` clears only on `rst`.
- `clear`:
  - Forces `acc <= 0`, `cnt <= 0`.
  - A coincident `in_valid` sample is discarded; `clear` wins, including on a completing sample.
  - FIFO contents and `overflow` are untouched.
- `out_sum` is `mem[rd_ptr]`. It holds stable while `out_valid && !out_ready`.

## Timing
- Reset values:
  - `out_valid=0`, `out_sum=0`, `busy=0`, `overflow=0`.
  - `acc=0`, `cnt=0`, pointers and `level` = 0.
- `rst` mid-frame or with a full FIFO discards everything in the next cycle. `rst` takes priority over `clear`, `in_valid` and `out_ready`.
- Latency: the completing sample at edge k gives `out_valid=1` after edge k, provided the FIFO was empty. It is a registered output with no combinational path from `in_valid` to `out_valid`.
- `out_valid` is `level != 0`, registered.
- Throughput: one product per cycle, sustained indefinitely, provided the consumer pops at least once per `LEN` cycles on average.
- `busy` rises after the first accepted sample of a frame. It falls after the completing sample or `clear`.

## Configuration
- `MULT_FRAME_ACC_DROP_CNT_EN` defined:
  - Adds output port `drop_cnt[7:0]`.
  - It counts dropped frames, saturating at 255 with no wrap.
  - It resets to 0 on `rst` only.
  - It increments on the same edge that sets `overflow`.
- Undefined:
  - The port and counter do not exist.
  - `overflow` behaviour is identical in both builds.

## Test plan
- **Single frame:** with N=M=4, LEN=8, feed `in_data` = 1,2,…,8 on consecutive cycles with `out_ready=1`. Required: `out_valid` pulses for 1 cycle with `out_sum=36`, one cycle after the 8th sample; `busy` is 1 for 7 cycles.
- **Maximum values:** feed 8 samples of 225 (15×15). Required: `out_sum=1800` (11-bit `ACC_W`, no wrap).
- **Back-to-back frames with gaps:** run 3 frames of all-1 with `in_valid` toggling randomly and `out_ready=1`. Required: three sums of 8, in order.
- **Backpressure:** hold `out_ready=0` and complete 3 frames. Required:
  - `level` reaches 2 and the first two sums are preserved in order.
  - The 3rd sum is dropped and `overflow=1`.
  - `drop_cnt=1` when the macro is defined.
  - Then assert `out_ready`: exactly two sums pop.
- **Full with simultaneous pop:** with `level=2`, complete a frame on the same edge as a pop. Required: the new sum is accepted, `level` stays 2, and `overflow` stays 0.
- **`clear` and `rst` mid-frame:** assert `clear` after 5 samples, coincident with a 6th sample. Required: that sample is ignored, `busy=0`, and the next frame of 1..8 sums to 36. Assert `rst` with `out_valid=1`. Required: all outputs are 0 on the next cycle.
